// File: rtl/pulse_in_capture.sv
// Pulse-width measurement on one selectable GPIO pin (hardware pulseIn()).
// Skips a pulse already in progress, then times the next pulse of the requested level.
module pulse_in_capture #(
    parameter int unsigned NPINS       = 32,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPINS-1:0]         pin_i,
    input  logic                     start_i,
    input  logic [$clog2(NPINS)-1:0] pin_sel_i,
    input  logic                     level_i,
    input  logic [CNT_WIDTH-1:0]     timeout_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [CNT_WIDTH-1:0]     width_o
);

    typedef enum logic [1:0] {IDLE, WAIT_END, WAIT_START, MEASURE} state_t;

    state_t                     state_q, state_d;
    logic [NPINS-1:0]           sync_q [SYNC_STAGES];
    logic [$clog2(NPINS)-1:0]   pin_sel_q, pin_sel_d;
    logic                       level_q, level_d;
    logic [CNT_WIDTH-1:0]       timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]       tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0]       wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]       width_q, width_d;
    logic                       tmo_flag_q, tmo_flag_d;
    logic                       done_q, done_d;

    logic                       s;
    logic                       at_level;
    logic [CNT_WIDTH-1:0]       tcnt_inc;
    logic [CNT_WIDTH-1:0]       wcnt_inc;
    logic                       tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1][pin_sel_q];
    assign at_level = (s == level_q);
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_WIDTH'(1);
    assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + CNT_WIDTH'(1);
    assign tmo_hit  = (timeout_q != '0) && (tcnt_inc == timeout_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // In MEASURE the end-of-pulse test precedes the timeout test so completion wins a tie.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start_i) state_d = WAIT_END;
            WAIT_END:   if (tmo_hit) state_d = IDLE; else if (!at_level) state_d = WAIT_START;
            WAIT_START: if (tmo_hit) state_d = IDLE; else if (at_level)  state_d = MEASURE;
            MEASURE:    if (!at_level || tmo_hit) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        pin_sel_d  = pin_sel_q;
        level_d    = level_q;
        timeout_d  = timeout_q;
        tcnt_d     = tcnt_q;
        wcnt_d     = wcnt_q;
        width_d    = width_q;
        tmo_flag_d = tmo_flag_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pin_sel_d  = pin_sel_i;
                    level_d    = level_i;
                    timeout_d  = timeout_i;
                    tcnt_d     = '0;
                    wcnt_d     = '0;
                    width_d    = '0;
                    tmo_flag_d = 1'b0;
                end
            end
            WAIT_END, WAIT_START: begin
                tcnt_d = tcnt_inc;
                if (tmo_hit) begin
                    done_d     = 1'b1;
                    tmo_flag_d = 1'b1;
                    width_d    = '0;
                end else if (state_q == WAIT_START && at_level) begin
                    wcnt_d = CNT_WIDTH'(1);
                end
            end
            MEASURE: begin
                tcnt_d = tcnt_inc;
                if (!at_level) begin
                    done_d     = 1'b1;
                    tmo_flag_d = 1'b0;
                    width_d    = wcnt_q;
                end else if (tmo_hit) begin
                    done_d     = 1'b1;
                    tmo_flag_d = 1'b1;
                    width_d    = '0;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_sel_q  <= '0;
            level_q    <= 1'b0;
            timeout_q  <= '0;
            tcnt_q     <= '0;
            wcnt_q     <= '0;
            width_q    <= '0;
            tmo_flag_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pin_sel_q  <= pin_sel_d;
            level_q    <= level_d;
            timeout_q  <= timeout_d;
            tcnt_q     <= tcnt_d;
            wcnt_q     <= wcnt_d;
            width_q    <= width_d;
            tmo_flag_q <= tmo_flag_d;
            done_q     <= done_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign timeout_o = tmo_flag_q;
    assign width_o   = width_q;

endmodule

// File: tb/tb_pulse_in_capture.sv
// Bench for pulse_in_capture: a 32-bit and an 8-bit counter instance on shared pads,
// checked every cycle against a history-scanning model plus directed literal checks.
module tb_pulse_in_capture;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pin_i = 32'h0000_0080;
    logic        start_i = 1'b0, start8_i = 1'b0;
    logic [4:0]  pin_sel_i = '0;
    logic        level_i = 1'b0;
    logic [31:0] timeout_i = '0;
    logic        busy0, done0, to0, busy1, done1, to1;
    logic [31:0] width0;
    logic [7:0]  width1;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    pulse_in_capture #(.NPINS(32), .CNT_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pin_i(pin_i), .start_i(start_i), .pin_sel_i(pin_sel_i),
        .level_i(level_i), .timeout_i(timeout_i), .busy_o(busy0), .done_o(done0),
        .timeout_o(to0), .width_o(width0));

    pulse_in_capture #(.NPINS(32), .CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .pin_i(pin_i), .start_i(start8_i), .pin_sel_i(pin_sel_i),
        .level_i(level_i), .timeout_i(timeout_i[7:0]), .busy_o(busy1), .done_o(done1),
        .timeout_o(to1), .width_o(width1));

    // Model: pad history per clock edge; a measurement's outcome is read off that history.
    logic [31:0] hist[$];
    int          rst_mark = 0;
    bit          m_busy[2], m_done[2], m_to[2], m_lvl[2];
    longint      m_width[2], m_tmo[2];
    int          m_a[2], m_sel[2];

    function automatic longint maxw(int u);
        return (u == 0) ? 64'hFFFF_FFFF : 64'd255;
    endfunction

    function automatic bit pinval(int idx, int sel);
        if (idx < 0 || idx < rst_mark) return 1'b0;
        return hist[idx][sel];
    endfunction

    // Synchronised level seen by unit u in its k-th busy cycle.
    function automatic bit s_at(int u, int k);
        return pinval(m_a[u] + k + 1 - SYNC, m_sel[u]);
    endfunction

    function automatic longint pulse_width(int u, int last);
        int i1, i2;
        bit s;
        i1 = -1;
        i2 = -1;
        for (int k = 0; k <= last; k++) begin
            s = s_at(u, k);
            if (i1 < 0) begin
                if (s != m_lvl[u]) i1 = k;
            end else if (i2 < 0) begin
                if (s == m_lvl[u]) i2 = k;
            end else if (s != m_lvl[u]) begin
                return longint'(k - i2);
            end
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_mark = hist.size();
            for (int u = 0; u < 2; u++) begin
                m_busy[u] = 0; m_done[u] = 0; m_to[u] = 0; m_width[u] = 0;
            end
        end else begin
            int     n, k;
            longint w;
            hist.push_back(pin_i);
            n = hist.size() - 1;
            for (int u = 0; u < 2; u++) begin
                m_done[u] = 0;
                if (m_busy[u]) begin
                    k = n - m_a[u] - 1;
                    w = -1;
                    if (s_at(u, k) != m_lvl[u]) w = pulse_width(u, k);
                    if (w >= 0) begin
                        m_busy[u] = 0; m_done[u] = 1; m_to[u] = 0;
                        m_width[u] = (w > maxw(u)) ? maxw(u) : w;
                    end else if (m_tmo[u] != 0 && longint'(k + 1) == m_tmo[u]) begin
                        m_busy[u] = 0; m_done[u] = 1; m_to[u] = 1; m_width[u] = 0;
                    end
                end else if ((u == 0) ? start_i : start8_i) begin
                    m_busy[u] = 1; m_a[u] = n; m_sel[u] = int'(pin_sel_i); m_lvl[u] = level_i;
                    m_tmo[u] = (u == 0) ? longint'(timeout_i) : longint'(timeout_i[7:0]);
                    m_width[u] = 0; m_to[u] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("cyc busy0",  busy0,  m_busy[0]);
        chk("cyc done0",  done0,  m_done[0]);
        chk("cyc to0",    to0,    m_to[0]);
        chk("cyc width0", width0, m_width[0]);
        chk("cyc busy1",  busy1,  m_busy[1]);
        chk("cyc done1",  done1,  m_done[1]);
        chk("cyc to1",    to1,    m_to[1]);
        chk("cyc width1", width1, m_width[1]);
    end

    task automatic do_start(input int u, input int sel, input bit lvl, input int tmo);
        pin_sel_i = 5'(sel);
        level_i   = lvl;
        timeout_i = 32'(tmo);
        if (u == 0) start_i = 1'b1; else start8_i = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        start8_i = 1'b0;
        chk($sformatf("start u%0d busy", u), (u == 0) ? busy0 : busy1, 1);
    endtask

    task automatic wait_done(input int u, input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (((u == 0) ? done0 : done1) === 1'b1) begin
                cyc = i;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done u%0d: got no done expected done within %0d cycles", u, limit);
    endtask

    task automatic count_done(input int u, input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (((u == 0) ? done0 : done1) === 1'b1) cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cnt;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy0", busy0, 0);
        chk("reset done0", done0, 0);
        chk("reset to0", to0, 0);
        chk("reset width0", width0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 500 us high pulse at 25 MHz
        do_start(0, 4, 1'b1, 0);
        repeat (5) @(negedge clk);
        pin_i[4] = 1'b1;
        repeat (12500) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(0, 50, c);
        n_checks++;
        if (width0 < 12499 || width0 > 12501) begin
            n_fail++;
            $display("FAIL t1 width: got %0d expected 12500+-1", width0);
        end
        chk("t1 timeout", to0, 0);
        chk("t1 busy at done", busy0, 0);
        count_done(0, 20, cnt);
        chk("t1 extra dones", cnt, 0);

        // pulse in progress at start is skipped
        pin_i[4] = 1'b1;
        repeat (5) @(negedge clk);
        do_start(0, 4, 1'b1, 0);
        repeat (200) @(negedge clk);
        pin_i[4] = 1'b0;
        repeat (50) @(negedge clk);
        pin_i[4] = 1'b1;
        repeat (300) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(0, 50, c);
        chk("t2 width", width0, 300);
        chk("t2 timeout", to0, 0);

        // low pulse on idle-high pin 7
        do_start(0, 7, 1'b0, 0);
        repeat (5) @(negedge clk);
        pin_i[7] = 1'b0;
        repeat (1000) @(negedge clk);
        pin_i[7] = 1'b1;
        wait_done(0, 50, c);
        chk("t3 width", width0, 1000);

        // timeout, then a back-to-back start in the done cycle
        do_start(0, 4, 1'b1, 1000);
        wait_done(0, 1100, c);
        chk("t4 done latency", c, 1000);
        chk("t4 timeout", to0, 1);
        chk("t4 width", width0, 0);
        do_start(0, 4, 1'b1, 5);
        wait_done(0, 20, c);
        chk("t4b done latency", c, 5);
        chk("t4b timeout", to0, 1);

        // completion on the final allowed busy cycle beats the timeout
        repeat (3) @(negedge clk);
        do_start(0, 4, 1'b1, 23);
        pin_i[4] = 1'b1;
        repeat (20) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(0, 40, c);
        chk("t6 tie width", width0, 20);
        chk("t6 tie timeout", to0, 0);
        repeat (3) @(negedge clk);
        do_start(0, 4, 1'b1, 22);
        pin_i[4] = 1'b1;
        repeat (20) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(0, 40, c);
        chk("t6 early timeout", to0, 1);
        chk("t6 early width", width0, 0);

        // 8-bit counter saturation, start while busy ignored
        repeat (3) @(negedge clk);
        do_start(1, 4, 1'b1, 0);
        repeat (5) @(negedge clk);
        pin_i[4] = 1'b1;
        repeat (100) @(negedge clk);
        pin_sel_i = 5'd7;
        level_i   = 1'b0;
        start8_i  = 1'b1;
        @(negedge clk);
        start8_i = 1'b0;
        repeat (199) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(1, 50, c);
        chk("t5 saturated width", width1, 255);
        chk("t5 timeout", to1, 0);
        count_done(1, 30, cnt);
        chk("t5 extra dones", cnt, 0);

        // reset in the middle of MEASURE
        do_start(0, 4, 1'b1, 0);
        repeat (3) @(negedge clk);
        pin_i[4] = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7 rst busy0", busy0, 0);
        chk("t7 rst done0", done0, 0);
        chk("t7 rst width0", width0, 0);
        chk("t7 rst width1", width1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pin_i[4] = 1'b0;
        count_done(0, 30, cnt);
        chk("t7 no done after reset", cnt, 0);
        do_start(0, 4, 1'b1, 0);
        repeat (5) @(negedge clk);
        pin_i[4] = 1'b1;
        repeat (77) @(negedge clk);
        pin_i[4] = 1'b0;
        wait_done(0, 50, c);
        chk("t7 fresh width", width0, 77);
        chk("t7 fresh timeout", to0, 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_in_capture.md
Name: pulse_in_capture

Overview:
Hardware pulse-width measurement unit for the Arduino-compatible software layer. It sits between the GPIO pad inputs (gpio_in) and the APB GPIO/peripheral register interface, and offloads pulseIn() from core busy-wait loops. It watches one selected GPIO pin and waits for any pulse already in progress to end. It then waits for a fresh pulse of the requested level and measures its width in clk cycles, with an optional overall timeout.

Parameters:
NPINS, 32, number of GPIO inputs observed
CNT_WIDTH, 32, width of the width and timeout counters
SYNC_STAGES, 2, synchroniser depth per pin (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pin_i  in  NPINS  raw asynchronous GPIO pad inputs
start_i  in  1  single-cycle request to start a measurement
pin_sel_i  in  $clog2(NPINS)  pin index, sampled on an accepted start
level_i  in  1  pulse polarity to measure (1 = high pulse), sampled on an accepted start
timeout_i  in  CNT_WIDTH  overall timeout in cycles; 0 = no timeout; sampled on an accepted start
busy_o  out  1  measurement in progress
done_o  out  1  one-cycle completion strobe
timeout_o  out  1  last measurement ended by timeout
width_o  out  CNT_WIDTH  last measured width in cycles

Behaviour:
- Reset (async assert, sync deassert via the existing flops): state IDLE; busy_o=0, done_o=0, timeout_o=0, width_o=0; all synchroniser flops=0; counters=0.
- Synchronisation: every pin passes through SYNC_STAGES flops. The mux selects s = synced[pin_sel_q]. Input-to-s latency is SYNC_STAGES cycles.
- Start acceptance:
  - start_i is accepted only in IDLE.
  - On acceptance: latch pin_sel_q, level_q and timeout_q; clear tcnt, wcnt, timeout_o and width_o.
  - busy_o=1 from the next cycle.
  - start_i while busy is ignored and has no side effects.
- FSM states:
  - IDLE: on start -> WAIT_END.
  - WAIT_END: if s!=level_q -> WAIT_START; else stay. This discards a pulse already in progress.
  - WAIT_START: if s==level_q -> MEASURE with wcnt=1; else stay.
  - MEASURE: if s==level_q, wcnt++ (saturating at all-ones); else width_o<=wcnt, done_o=1, busy_o=0 -> IDLE.
- Timeout:
  - tcnt increments every cycle in WAIT_END, WAIT_START and MEASURE.
  - If timeout_q!=0 and tcnt+1==timeout_q in any of those states: -> IDLE, done_o=1, timeout_o=1, width_o=0.
  - This gives exactly timeout_q busy cycles.
  - If pulse completion and timeout occur in the same cycle, completion wins (timeout_o=0, valid width_o).
- Width semantics: width_o = number of clk cycles s was at level_q, which equals the pad pulse width rounded to clk cycles.
- Outputs:
  - done_o is registered and high for exactly one cycle.
  - busy_o falls in the same cycle done_o rises.
  - width_o and timeout_o hold until the next accepted start.
- A new start is acceptable in the cycle after done_o (back-to-back measurements are allowed).
- Reset mid-measurement: immediate return to IDLE with all outputs 0. No done_o is produced.
- tcnt saturates and never wraps. With timeout_q=0 the unit waits indefinitely.

Test Plan:
- clk 25 MHz, pin 4 low, start (sel=4, level=1, timeout=0); pin 4 high for 500 us then low -> done_o once, width_o=12500 (±1), timeout_o=0, busy_o low after done.
- Pin 4 already high at start; it falls after 200 cycles, then a 300-cycle high pulse follows -> the first pulse is ignored, width_o=300.
- level=0, pin 7 idle high, 1000-cycle low pulse -> width_o=1000.
- timeout=1000, pin held low -> done_o exactly 1000 cycles after busy_o rises, timeout_o=1, width_o=0.
- CNT_WIDTH=8, 300-cycle pulse -> width_o=255 (saturated). Start pulsed while busy -> latched sel/level unchanged, single done_o.
- rst_n asserted mid-MEASURE -> busy_o/done_o/width_o=0 immediately, no done_o after release. A fresh start then measures correctly.
